seq_grid_renderer: RTL
======================

Name: seq_grid_renderer

Overview:
- Draws the 4-track x 16-step sequencer grid into the 160x120 VGA frame buffer, one pixel per clock.
- Sits between the four speakerPlay step patterns/beat counter and the vga_adapter x/y/colour/plot inputs.
- Snapshots its inputs at the start of each frame and redraws only when something has changed, so no partial-frame tearing reaches the buffer.

Parameters:
X0, 20, x of the grid's top-left pixel
Y0, 30, y of the grid's top-left pixel
CELL, 4, cell edge in pixels (CELL x CELL square)
GAP, 1, blank pixels between cells; pitch P = CELL+GAP

Ports:
clk  input  1  system clock (CLOCK_50)
reset  input  1  synchronous, active-high reset
enable  input  1  allows a new frame to start
pattern0  input  16  track 0 steps; step s = bit (15-s)
pattern1  input  16  track 1 steps
pattern2  input  16  track 2 steps
pattern3  input  16  track 3 steps
beat  input  4  current playhead step 0..15
x  output  8  pixel x to vga_adapter
y  output  7  pixel y to vga_adapter
colour  output  3  pixel colour {R,G,B}
plot  output  1  pixel valid / write strobe
busy  output  1  high from LATCH through last DRAW cycle
frame_done  output  1  one-cycle pulse after the last pixel

Behaviour:
- Reset (sync, takes effect at the clock edge): x=0, y=0, colour=0, plot=0, busy=0, frame_done=0.
  - State goes to IDLE; the force flag is set; all counters are cleared.
  - Reset mid-frame aborts immediately: plot=0 from the next edge, no frame_done.
- FSM states: IDLE, LATCH, DRAW, DONE.
- IDLE:
  - The trigger is enable=1 AND (force=1 OR any of pattern0..3 or beat differs from the snapshot).
  - On trigger, go to LATCH.
- LATCH (1 cycle):
  - Snapshot pattern0..3 and beat, clear force, clear counters r,s,py,px, set busy=1.
  - Next state is DRAW.
- DRAW:
  - Each cycle registers one pixel with plot=1.
  - Counter order: px fastest (0..CELL-1), then py, then s (0..15), then r (0..3) slowest.
  - x = X0 + s*P + px; y = Y0 + r*P + py. Compute at full width, then truncate to 8 and 7 bits. Defaults keep max x=98 and max y=48, so no wrap occurs.
  - Colour is taken from the snapshot, with on = bit(15-s) of pattern r and head = (s == beat):
    - on and head -> 3'b110
    - on and not head -> 3'b010
    - not on and head -> 3'b001
    - not on and not head -> 3'b100
  - Exactly 4*16*CELL*CELL cycles (1024 at defaults) of contiguous plot=1. Gap pixels are never written.
  - On the last pixel (r=3, s=15, py=px=CELL-1), go to DONE.
- DONE (1 cycle): plot=0, busy=0, frame_done=1. Next state is IDLE.
- Latency:
  - Trigger seen in IDLE at edge t.
  - LATCH at t+1.
  - First pixel (X0,Y0) has plot=1 during the cycle after edge t+2.
  - frame_done asserts 1 cycle after the last plot.
- Input changes during LATCH/DRAW/DONE are ignored for the current frame. They differ from the snapshot and so retrigger from IDLE.
- enable deasserted mid-frame does not stop the frame; it only blocks the next start.
- Outputs outside DRAW: plot=0, and x/y/colour hold their last values.
- Back-to-back frames: minimum 3 idle-to-pixel overhead cycles (DONE, IDLE, LATCH) between frames.

Test Plan:
- Reset released, enable=1, all patterns 0, beat=0 -> one frame of 1024 plots.
  - First pixel (20,30) colour 3'b001.
  - Pixel (25,30) colour 3'b100.
  - frame_done pulses once; no second frame while inputs stay constant.
- pattern2=16'h8001, beat=15 -> pixel (20,40) is 3'b010; pixel (95,40) is 3'b110; pixel (95,30) is 3'b001.
  - No plot ever occurs at x=24 or y=34 (gap pixels).
- beat changes 3->4 at DRAW pixel 100 -> current frame still uses beat=3 throughout; a second frame starts after DONE using beat=4.
- reset pulsed at DRAW pixel 500 -> plot=0 the next cycle, no frame_done.
  - After release with enable=1, a full 1024-pixel frame runs (force flag).
- enable=0 after reset -> no plot for 2000 cycles.
  - Raise enable -> first plot exactly 2 cycles after the edge where enable is sampled high.
- Drop enable during DRAW -> frame completes with all 1024 plots; pattern changes afterwards cause no new frame until enable=1.

Source files
------------

// File: rtl/seq_grid_renderer.sv
// Renders a 4-track x 16-step sequencer grid into a VGA frame buffer, one pixel per clock.
// Inputs are snapshotted at frame start; a new frame is drawn only when they change.
module seq_grid_renderer #(
    parameter int X0   = 20,
    parameter int Y0   = 30,
    parameter int CELL = 4,
    parameter int GAP  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] pattern0,
    input  logic [15:0] pattern1,
    input  logic [15:0] pattern2,
    input  logic [15:0] pattern3,
    input  logic [3:0]  beat,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        frame_done
);

    localparam int P  = CELL + GAP;
    localparam int CW = (CELL > 1) ? $clog2(CELL) : 1;
    localparam logic [CW-1:0] CELL_MAX = CW'(CELL - 1);

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        DRAW,
        DONE
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [3:0][15:0] pat_in;
    logic [3:0][15:0] pat_snap_reg;
    logic [3:0]       beat_snap_reg;
    logic             force_reg;
    logic [3:0]       pat_diff;

    logic [CW-1:0] px_reg;
    logic [CW-1:0] py_reg;
    logic [3:0]    s_reg;
    logic [1:0]    r_reg;

    logic       trigger;
    logic       last_pixel;
    logic       cell_on;
    logic       cell_head;
    logic [7:0] x_next;
    logic [6:0] y_next;
    logic [2:0] colour_next;

    assign pat_in = {pattern3, pattern2, pattern1, pattern0};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_diff
            assign pat_diff[gi] = (pat_in[gi] != pat_snap_reg[gi]);
        end
    endgenerate

    // force_reg guarantees one full redraw after reset even if inputs match the snapshot
    assign trigger    = enable && (force_reg || (|pat_diff) || (beat != beat_snap_reg));
    assign last_pixel = (r_reg == 2'd3) && (s_reg == 4'd15) &&
                        (py_reg == CELL_MAX) && (px_reg == CELL_MAX);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (trigger) state_next = LATCH;
            LATCH:   state_next = DRAW;
            DRAW:    if (last_pixel) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Pixel coordinate and colour for the current counter position, from the snapshot only
    always_comb begin
        x_next      = 8'(X0 + int'(s_reg) * P + int'(px_reg));
        y_next      = 7'(Y0 + int'(r_reg) * P + int'(py_reg));
        cell_on     = pat_snap_reg[r_reg][4'd15 - s_reg];
        cell_head   = (s_reg == beat_snap_reg);
        colour_next = 3'b100;
        if (cell_on && cell_head) begin
            colour_next = 3'b110;
        end else if (cell_on) begin
            colour_next = 3'b010;
        end else if (cell_head) begin
            colour_next = 3'b001;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x             <= '0;
            y             <= '0;
            colour        <= '0;
            plot          <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            force_reg     <= 1'b1;
            pat_snap_reg  <= '0;
            beat_snap_reg <= '0;
            px_reg        <= '0;
            py_reg        <= '0;
            s_reg         <= '0;
            r_reg         <= '0;
        end else begin
            case (state_reg)
                LATCH: begin
                    pat_snap_reg  <= pat_in;
                    beat_snap_reg <= beat;
                    force_reg     <= 1'b0;
                    px_reg        <= '0;
                    py_reg        <= '0;
                    s_reg         <= '0;
                    r_reg         <= '0;
                    busy          <= 1'b1;
                    plot          <= 1'b0;
                    frame_done    <= 1'b0;
                end
                DRAW: begin
                    x          <= x_next;
                    y          <= y_next;
                    colour     <= colour_next;
                    plot       <= 1'b1;
                    frame_done <= 1'b0;
                    // px fastest, then py, then step, then track
                    if (px_reg == CELL_MAX) begin
                        px_reg <= '0;
                        if (py_reg == CELL_MAX) begin
                            py_reg <= '0;
                            if (s_reg == 4'd15) begin
                                s_reg <= '0;
                                r_reg <= r_reg + 2'd1;
                            end else begin
                                s_reg <= s_reg + 4'd1;
                            end
                        end else begin
                            py_reg <= py_reg + CW'(1);
                        end
                    end else begin
                        px_reg <= px_reg + CW'(1);
                    end
                end
                DONE: begin
                    plot       <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
                default: begin
                    plot       <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
